debounce_sensores: RTL
======================

Name: debounce_sensores

Overview:
- Upstream conditioning stage for the parking-meter car counter.
- Takes the two raw, asynchronous, bouncy optical/contact sensor lines (first and second sensor).
- Synchronizes each line into the clk domain and debounces it with a per-channel state machine and stability counter.
- Drives clean levels straight into the counter FSM's psensor/ssensor inputs, plus one-cycle edge ticks and saturating bounce counters for diagnostics.

Parameters:
- DB_BITS, 20, width of each stability counter. Required stable time is 2^DB_BITS cycles (about 21 ms at 50 MHz). Benches override it to 3.
- RB_BITS, 8, width of each saturating bounce counter.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
psensor_raw  input  1  raw first sensor, asynchronous to clk
ssensor_raw  input  1  raw second sensor, asynchronous to clk
clr_rebotes  input  1  synchronous clear of both bounce counters
psensor  output  1  debounced first sensor level (to counter FSM)
ssensor  output  1  debounced second sensor level (to counter FSM)
p_sube  output  1  one-cycle pulse when psensor goes 0->1
p_baja  output  1  one-cycle pulse when psensor goes 1->0
s_sube  output  1  one-cycle pulse when ssensor goes 0->1
s_baja  output  1  one-cycle pulse when ssensor goes 1->0
rebotes_p  output  RB_BITS  aborted transitions on first sensor, saturating
rebotes_s  output  RB_BITS  aborted transitions on second sensor, saturating

Behaviour:

Reset and synchronizer
- Reset (async, active-high) clears all state: sync flops, FSMs to ESTABLE0, counters, all outputs.
- All outputs are 0 during reset.
- Each raw line passes through two flops (sync1, sync2). Only sync2 (called "s") feeds logic.

Per-channel FSM (two identical, independent instances)
- States: ESTABLE0, ESPERA1, ESTABLE1, ESPERA0. Counter cnt is DB_BITS wide; MAX = 2^DB_BITS-1.
- ESTABLE0: out=0.
  - s=1: go to ESPERA1, cnt<=0.
  - Otherwise stay.
- ESPERA1: out=0.
  - s=0: go to ESTABLE0 and increment bounce counter.
  - s=1 and cnt==MAX: go to ESTABLE1, out<=1, sube pulse.
  - Otherwise cnt<=cnt+1.
- ESTABLE1: out=1.
  - s=0: go to ESPERA0, cnt<=0.
- ESPERA0: symmetric to ESPERA1.
  - s=1: back to ESTABLE1 and increment bounce counter.
  - cnt==MAX with s=0: go to ESTABLE0, out<=0, baja pulse.
- Unreachable state encodings go to ESTABLE0 with out<=0 and no pulse.

Latency
- Raw level changes and is held from just before edge k. Sync2 shows it after edge k+1, the FSM leaves ESTABLE at edge k+2, and out changes at edge k+2+2^DB_BITS.
- A raw pulse is accepted only if it is stable for at least 2^DB_BITS+1 consecutive sampled cycles.
- Any glitch that aborts an ESPERA state restarts the full count on the next qualifying edge.

Outputs
- psensor, ssensor, p_sube, p_baja, s_sube and s_baja are registered.
- Each tick is high for exactly the one cycle following the edge where out changes.
- sube and baja of one channel are never high together. Both channels may pulse in the same cycle.

Bounce counters
- Each increments by 1 per aborted ESPERA state and saturates at 2^RB_BITS-1. They never wrap.
- clr_rebotes clears both on the next edge and takes priority over a simultaneous increment.
- The counters are not reset by FSM activity, only by reset or clr_rebotes.

Boundary cases
- Raw held at 1 through reset release: treated as a normal 0->1 transition. psensor rises 2+2^DB_BITS edges after the first edge following release.
- Reset asserted mid-ESPERA: immediate clear with no pulse. The stale count is not retained.
- Channels share nothing except clk, reset and clr_rebotes.

Test Plan:
All scenarios use DB_BITS=3, RB_BITS=3.
1. Reset, then drive psensor_raw=1 from just before edge k -> psensor=1 after edge k+10, p_sube high one cycle, rebotes_p=0, ssensor stays 0.
2. psensor_raw 1 for 5 cycles, then 0, then 1 held -> no psensor change during the glitch, rebotes_p=1, psensor rises 10 edges after the final rise.
3. Full car sequence: p up, s up, p down, s down, each held 20 cycles -> psensor/ssensor reproduce the order with a 10-cycle lag and four single-cycle ticks in matching order.
4. Chatter of 9 aborted transitions on ssensor_raw -> rebotes_s saturates at 7 and does not wrap. Pulse clr_rebotes -> 0 next cycle. clr_rebotes coincident with an abort -> 0.
5. Assert reset while the p channel is in ESPERA1 at cnt=5 -> all outputs 0 immediately, no p_sube. After release with raw still 1, a full 10-edge qualification is required again.
6. Both raw lines rise on the same edge -> psensor and ssensor rise on the same edge, and p_sube and s_sube coincide.

Source files
------------

// File: rtl/debounce_sensores.sv
// Sensor conditioning for the parking-meter car counter: two-flop synchronizer,
// per-channel debounce FSM, edge ticks and saturating bounce counters.

module debounce_canal #(
  parameter int DB_BITS = 20,
  parameter int RB_BITS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_raw,
  input  logic               i_clr,
  output logic               o_nivel,
  output logic               o_sube,
  output logic               o_baja,
  output logic [RB_BITS-1:0] o_rebotes
);

  typedef enum logic [1:0] {
    ESTABLE0 = 2'b00,
    ESPERA1  = 2'b01,
    ESTABLE1 = 2'b11,
    ESPERA0  = 2'b10
  } estado_t;

  localparam logic [DB_BITS-1:0] CNT_MAX = '1;
  localparam logic [DB_BITS-1:0] CNT_UNO = DB_BITS'(1);
  localparam logic [RB_BITS-1:0] RB_MAX  = '1;
  localparam logic [RB_BITS-1:0] RB_UNO  = RB_BITS'(1);

  logic               r_sync1;
  logic               r_sync2;
  estado_t            r_estado;
  logic [DB_BITS-1:0] r_cnt;
  logic               r_nivel;
  logic               r_sube;
  logic               r_baja;
  logic [RB_BITS-1:0] r_rebotes;
  logic               w_s;
  logic               w_abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;
  // A wait state that sees the old level again is an aborted transition.
  assign w_abort = ((r_estado == ESPERA1) && !w_s) ||
                   ((r_estado == ESPERA0) &&  w_s);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado <= ESTABLE0;
      r_cnt    <= '0;
      r_nivel  <= 1'b0;
      r_sube   <= 1'b0;
      r_baja   <= 1'b0;
    end else begin
      r_sube <= 1'b0;
      r_baja <= 1'b0;
      case (r_estado)
        ESTABLE0: begin
          if (w_s) begin
            r_estado <= ESPERA1;
            r_cnt    <= '0;
          end
        end
        ESPERA1: begin
          if (!w_s) begin
            r_estado <= ESTABLE0;
          end else if (r_cnt == CNT_MAX) begin
            r_estado <= ESTABLE1;
            r_nivel  <= 1'b1;
            r_sube   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_UNO;
          end
        end
        ESTABLE1: begin
          if (!w_s) begin
            r_estado <= ESPERA0;
            r_cnt    <= '0;
          end
        end
        ESPERA0: begin
          if (w_s) begin
            r_estado <= ESTABLE1;
          end else if (r_cnt == CNT_MAX) begin
            r_estado <= ESTABLE0;
            r_nivel  <= 1'b0;
            r_baja   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_UNO;
          end
        end
        default: begin
          r_estado <= ESTABLE0;
          r_nivel  <= 1'b0;
        end
      endcase
    end
  end

  // Clear wins over a same-cycle abort; the count sticks at its maximum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rebotes <= '0;
    end else if (i_clr) begin
      r_rebotes <= '0;
    end else if (w_abort && (r_rebotes != RB_MAX)) begin
      r_rebotes <= r_rebotes + RB_UNO;
    end
  end

  assign o_nivel   = r_nivel;
  assign o_sube    = r_sube;
  assign o_baja    = r_baja;
  assign o_rebotes = r_rebotes;

endmodule

module debounce_sensores #(
  parameter int DB_BITS = 20,
  parameter int RB_BITS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               psensor_raw,
  input  logic               ssensor_raw,
  input  logic               clr_rebotes,
  output logic               psensor,
  output logic               ssensor,
  output logic               p_sube,
  output logic               p_baja,
  output logic               s_sube,
  output logic               s_baja,
  output logic [RB_BITS-1:0] rebotes_p,
  output logic [RB_BITS-1:0] rebotes_s
);

  debounce_canal #(
    .DB_BITS(DB_BITS),
    .RB_BITS(RB_BITS)
  ) u_canal_p (
    .clk      (clk),
    .reset    (reset),
    .i_raw    (psensor_raw),
    .i_clr    (clr_rebotes),
    .o_nivel  (psensor),
    .o_sube   (p_sube),
    .o_baja   (p_baja),
    .o_rebotes(rebotes_p)
  );

  debounce_canal #(
    .DB_BITS(DB_BITS),
    .RB_BITS(RB_BITS)
  ) u_canal_s (
    .clk      (clk),
    .reset    (reset),
    .i_raw    (ssensor_raw),
    .i_clr    (clr_rebotes),
    .o_nivel  (ssensor),
    .o_sube   (s_sube),
    .o_baja   (s_baja),
    .o_rebotes(rebotes_s)
  );

endmodule
